// File: rtl/zbt_image_reader.sv
// ZBT image reader: fetches a burst of 36-bit words from ZBT SRAM and unpacks
// each word into four 8-bit pixels (byte 0 first) on a valid/ready stream.
//
// Ports:
//   clk, reset        - rising-edge clock, synchronous active-high reset
//   start             - one-cycle burst request (ignored while busy)
//   base_addr         - first ZBT word address of the burst
//   num_words         - burst length in words (0 gives an immediate done pulse)
//   zbt_addr, zbt_re  - registered ZBT read address and strobe
//   zbt_rdata         - read data, valid RD_LAT cycles after its zbt_re
//   pixel, pixel_valid, pixel_ready - unpacked pixel stream
//   busy              - burst in progress
//   done              - one-cycle pulse after the last pixel is accepted
module zbt_image_reader #(
  parameter int unsigned ADDR_W = 19,
  parameter int unsigned RD_LAT = 2
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic [ADDR_W-1:0] base_addr,
  input  logic [ADDR_W-1:0] num_words,
  output logic [ADDR_W-1:0] zbt_addr,
  output logic              zbt_re,
  input  logic [35:0]       zbt_rdata,
  output logic [7:0]        pixel,
  output logic              pixel_valid,
  input  logic              pixel_ready,
  output logic              busy,
  output logic              done
);

  typedef enum logic [1:0] {StIdle, StFetch, StDrain} state_e;

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] next_addr_q, next_addr_d;  // address of the next read to issue
  logic [ADDR_W-1:0] remaining_q, remaining_d;  // reads still to issue
  logic [ADDR_W-1:0] zbt_addr_q, zbt_addr_d;
  logic              zbt_re_q, zbt_re_d;
  logic              done_q, done_d;
  logic [RD_LAT-1:0] inflight_q;

  logic [31:0] fifo_mem_q [4];
  logic [1:0]  wr_ptr_q, rd_ptr_q;
  logic [2:0]  count_q;
  logic [1:0]  idx_q;

  logic [2:0]  outstanding;
  logic [3:0]  occupancy;
  logic [31:0] head;
  logic        issue, fifo_wr, accept, fifo_pop, last_accept;
  logic        unused_rdata;

  assign unused_rdata = ^zbt_rdata[35:32];

  // Reads on the bus now plus reads still in the latency pipe; the tap stage is
  // counted because its word lands in the FIFO only at the end of this cycle.
  always_comb begin
    outstanding = {2'b00, zbt_re_q};
    for (int i = 0; i < int'(RD_LAT); i++) begin
      outstanding = outstanding + {2'b00, inflight_q[i]};
    end
  end

  // Pops are ignored here, so issuing never lets the FIFO overflow.
  assign occupancy = {1'b0, outstanding} + {1'b0, count_q};
  assign issue     = (state_q == StFetch) && (remaining_q != '0) && (occupancy < 4'd4);
  assign fifo_wr   = inflight_q[RD_LAT-1];

  assign head        = fifo_mem_q[rd_ptr_q];
  assign pixel_valid = (count_q != 3'd0);
  assign pixel       = pixel_valid ? head[{idx_q, 3'b000} +: 8] : 8'h00;
  assign accept      = pixel_valid && pixel_ready;
  assign fifo_pop    = accept && (idx_q == 2'd3);
  assign last_accept = (state_q == StDrain) && fifo_pop && (count_q == 3'd1) &&
                       (outstanding == 3'd0);

  always_comb begin
    state_d     = state_q;
    next_addr_d = next_addr_q;
    remaining_d = remaining_q;
    zbt_addr_d  = zbt_addr_q;
    zbt_re_d    = 1'b0;
    done_d      = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (start) begin
          if (num_words != '0) begin
            next_addr_d = base_addr;
            remaining_d = num_words;
            state_d     = StFetch;
          end else begin
            done_d = 1'b1;
          end
        end
      end
      StFetch: begin
        if (issue) begin
          zbt_re_d    = 1'b1;
          zbt_addr_d  = next_addr_q;
          next_addr_d = next_addr_q + 1'b1;
          remaining_d = remaining_q - 1'b1;
        end
        // remaining reaches zero in the cycle the last strobe is on the bus
        if (remaining_q == '0) begin
          state_d = StDrain;
        end
      end
      StDrain: begin
        if (last_accept) begin
          state_d = StIdle;
          done_d  = 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= StIdle;
      next_addr_q <= '0;
      remaining_q <= '0;
      zbt_addr_q  <= '0;
      zbt_re_q    <= 1'b0;
      done_q      <= 1'b0;
      inflight_q  <= '0;
      wr_ptr_q    <= 2'd0;
      rd_ptr_q    <= 2'd0;
      count_q     <= 3'd0;
      idx_q       <= 2'd0;
    end else begin
      state_q     <= state_d;
      next_addr_q <= next_addr_d;
      remaining_q <= remaining_d;
      zbt_addr_q  <= zbt_addr_d;
      zbt_re_q    <= zbt_re_d;
      done_q      <= done_d;
      inflight_q[0] <= zbt_re_q;
      for (int i = 1; i < int'(RD_LAT); i++) begin
        inflight_q[i] <= inflight_q[i-1];
      end
      if (fifo_wr) wr_ptr_q <= wr_ptr_q + 2'd1;
      if (fifo_pop) rd_ptr_q <= rd_ptr_q + 2'd1;
      count_q <= count_q + {2'b00, fifo_wr} - {2'b00, fifo_pop};
      if (accept) idx_q <= idx_q + 2'd1;
    end
  end

  // Storage needs no reset: pixel is gated by the reset-cleared count.
  always_ff @(posedge clk) begin
    if (!reset && fifo_wr) begin
      fifo_mem_q[wr_ptr_q] <= zbt_rdata[31:0];
    end
  end

  assign zbt_addr = zbt_addr_q;
  assign zbt_re   = zbt_re_q;
  assign busy     = (state_q != StIdle);
  assign done     = done_q;

endmodule
